// File: rtl/id_ex_stage.sv
// RiSC-16 ID/EX pipeline register with ALU operand select and load-use detection.
// Define RISC16_FWD_EN to enable MEM/WB bypassing; otherwise any RAW hazard stalls decode.
module id_ex_stage #(
    parameter int p_WORD_LEN = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_dec_valid,
    input  logic [2:0]            i_dec_opcode,
    input  logic [2:0]            i_dec_ra,
    input  logic [2:0]            i_dec_rb,
    input  logic [2:0]            i_dec_rc,
    input  logic [p_WORD_LEN-1:0] i_dec_imm,
    input  logic [p_WORD_LEN-1:0] i_dec_pc,
    input  logic [p_WORD_LEN-1:0] i_rf_a,
    input  logic [p_WORD_LEN-1:0] i_rf_b,
    input  logic [p_WORD_LEN-1:0] i_rf_c,
    input  logic                  i_mem_wr_en,
    input  logic [2:0]            i_mem_wr_idx,
    input  logic [p_WORD_LEN-1:0] i_mem_wr_data,
    input  logic                  i_wb_wr_en,
    input  logic [2:0]            i_wb_wr_idx,
    input  logic [p_WORD_LEN-1:0] i_wb_wr_data,
    input  logic                  i_stall,
    input  logic                  i_flush,
    output logic                  o_load_use,
    output logic                  o_valid,
    output logic                  o_alu_op,
    output logic [p_WORD_LEN-1:0] o_alu_ina,
    output logic [p_WORD_LEN-1:0] o_alu_inb,
    output logic [p_WORD_LEN-1:0] o_store_data,
    output logic [p_WORD_LEN-1:0] o_jump_target,
    output logic [p_WORD_LEN-1:0] o_pc,
    output logic [2:0]            o_opcode,
    output logic                  o_wr_en,
    output logic [2:0]            o_wr_idx
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    localparam logic [p_WORD_LEN-1:0] ZERO_W = {p_WORD_LEN{1'b0}};
    localparam logic [p_WORD_LEN-1:0] ONE_W  = {{(p_WORD_LEN-1){1'b0}}, 1'b1};

    function automatic logic reads_a(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_BEQ);
    endfunction

    function automatic logic reads_b(input logic [2:0] op);
        return (op != OP_LUI);
    endfunction

    function automatic logic reads_c(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_NAND);
    endfunction

    function automatic logic writes_reg(input logic [2:0] op);
        return (op != OP_SW) && (op != OP_BEQ);
    endfunction

    function automatic logic src_hit(input logic [2:0] op, input logic [2:0] ra,
                                     input logic [2:0] rb, input logic [2:0] rc,
                                     input logic [2:0] idx);
        return (reads_a(op) && (ra == idx)) ||
               (reads_b(op) && (rb == idx)) ||
               (reads_c(op) && (rc == idx));
    endfunction

    logic                  valid_q, valid_d;
    logic                  wr_en_q, wr_en_d;
    logic [2:0]            opcode_q, opcode_d;
    logic [2:0]            ra_q, ra_d;
    logic [2:0]            rb_q, rb_d;
    logic [2:0]            rc_q, rc_d;
    logic [p_WORD_LEN-1:0] imm_q, imm_d;
    logic [p_WORD_LEN-1:0] pc_q, pc_d;
    logic [p_WORD_LEN-1:0] a_q, a_d;
    logic [p_WORD_LEN-1:0] b_q, b_d;
    logic [p_WORD_LEN-1:0] c_q, c_d;

    logic                  hazard_s;
    logic                  load_use_s;
    logic [p_WORD_LEN-1:0] cap_a_s, cap_b_s, cap_c_s;
    logic [p_WORD_LEN-1:0] fa_s, fb_s, fc_s;
    logic [p_WORD_LEN-1:0] alu_ina_s, alu_inb_s;

`ifdef RISC16_FWD_EN
    function automatic logic [p_WORD_LEN-1:0] fwd_val(
        input logic [2:0]            idx,
        input logic [p_WORD_LEN-1:0] latched,
        input logic                  mem_en,
        input logic [2:0]            mem_idx,
        input logic [p_WORD_LEN-1:0] mem_data,
        input logic                  wb_en,
        input logic [2:0]            wb_idx,
        input logic [p_WORD_LEN-1:0] wb_data
    );
        logic [p_WORD_LEN-1:0] res;
        if (idx == 3'd0) begin
            res = ZERO_W;
        end else if (mem_en && (mem_idx == idx)) begin
            res = mem_data;
        end else if (wb_en && (wb_idx == idx)) begin
            res = wb_data;
        end else begin
            res = latched;
        end
        return res;
    endfunction

    // Only a load in EX cannot be bypassed in time; everything else forwards.
    always_comb begin
        hazard_s = valid_q && wr_en_q && (opcode_q == OP_LW) &&
                   src_hit(i_dec_opcode, i_dec_ra, i_dec_rb, i_dec_rc, ra_q);
    end

    // Capture-time bypass of the write committing this cycle.
    always_comb begin
        cap_a_s = (i_wb_wr_en && (i_wb_wr_idx != 3'd0) && (i_wb_wr_idx == i_dec_ra)) ? i_wb_wr_data : i_rf_a;
        cap_b_s = (i_wb_wr_en && (i_wb_wr_idx != 3'd0) && (i_wb_wr_idx == i_dec_rb)) ? i_wb_wr_data : i_rf_b;
        cap_c_s = (i_wb_wr_en && (i_wb_wr_idx != 3'd0) && (i_wb_wr_idx == i_dec_rc)) ? i_wb_wr_data : i_rf_c;
    end

    // EX-side forwarding of latched sources from the live MEM/WB writes.
    always_comb begin
        fa_s = fwd_val(ra_q, a_q, i_mem_wr_en, i_mem_wr_idx, i_mem_wr_data, i_wb_wr_en, i_wb_wr_idx, i_wb_wr_data);
        fb_s = fwd_val(rb_q, b_q, i_mem_wr_en, i_mem_wr_idx, i_mem_wr_data, i_wb_wr_en, i_wb_wr_idx, i_wb_wr_data);
        fc_s = fwd_val(rc_q, c_q, i_mem_wr_en, i_mem_wr_idx, i_mem_wr_data, i_wb_wr_en, i_wb_wr_idx, i_wb_wr_data);
    end
`else
    logic unused_fwd_s;

    // Without bypassing, decode waits until every in-flight writer has reached the register file.
    always_comb begin
        hazard_s = (valid_q && wr_en_q &&
                    src_hit(i_dec_opcode, i_dec_ra, i_dec_rb, i_dec_rc, ra_q)) ||
                   (i_mem_wr_en && (i_mem_wr_idx != 3'd0) &&
                    src_hit(i_dec_opcode, i_dec_ra, i_dec_rb, i_dec_rc, i_mem_wr_idx)) ||
                   (i_wb_wr_en && (i_wb_wr_idx != 3'd0) &&
                    src_hit(i_dec_opcode, i_dec_ra, i_dec_rb, i_dec_rc, i_wb_wr_idx));
    end

    // Operands come straight from the latched register-file reads.
    always_comb begin
        cap_a_s = i_rf_a;
        cap_b_s = i_rf_b;
        cap_c_s = i_rf_c;
        fa_s    = a_q;
        fb_s    = b_q;
        fc_s    = c_q;
    end

    assign unused_fwd_s = ^{i_mem_wr_data, i_wb_wr_data, rb_q, rc_q};
`endif

    // Load-use request, suppressed by a flush since the decode slot is squashed anyway.
    always_comb begin
        load_use_s = i_dec_valid && !i_flush && hazard_s;
    end

    // Next-state: flush bubble, stall hold, load-use bubble, else capture.
    always_comb begin
        valid_d  = valid_q;
        wr_en_d  = wr_en_q;
        opcode_d = opcode_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        if (i_flush || (!i_stall && load_use_s)) begin
            valid_d  = 1'b0;
            wr_en_d  = 1'b0;
            opcode_d = OP_ADD;
            ra_d     = 3'd0;
            rb_d     = 3'd0;
            rc_d     = 3'd0;
            imm_d    = ZERO_W;
            pc_d     = ZERO_W;
            a_d      = ZERO_W;
            b_d      = ZERO_W;
            c_d      = ZERO_W;
        end else if (!i_stall) begin
            valid_d  = i_dec_valid;
            wr_en_d  = i_dec_valid && writes_reg(i_dec_opcode) && (i_dec_ra != 3'd0);
            opcode_d = i_dec_opcode;
            ra_d     = i_dec_ra;
            rb_d     = i_dec_rb;
            rc_d     = i_dec_rc;
            imm_d    = i_dec_imm;
            pc_d     = i_dec_pc;
            a_d      = cap_a_s;
            b_d      = cap_b_s;
            c_d      = cap_c_s;
        end else begin
            valid_d  = valid_q;
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            opcode_q <= 3'd0;
            ra_q     <= 3'd0;
            rb_q     <= 3'd0;
            rc_q     <= 3'd0;
            imm_q    <= ZERO_W;
            pc_q     <= ZERO_W;
            a_q      <= ZERO_W;
            b_q      <= ZERO_W;
            c_q      <= ZERO_W;
        end else begin
            valid_q  <= valid_d;
            wr_en_q  <= wr_en_d;
            opcode_q <= opcode_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
        end
    end

    // ALU operand map per opcode.
    always_comb begin
        alu_ina_s = fb_s;
        alu_inb_s = fc_s;
        case (opcode_q)
            OP_ADD, OP_NAND: begin
                alu_ina_s = fb_s;
                alu_inb_s = fc_s;
            end
            OP_ADDI, OP_LW, OP_SW: begin
                alu_ina_s = fb_s;
                alu_inb_s = imm_q;
            end
            OP_LUI: begin
                alu_ina_s = imm_q;
                alu_inb_s = ZERO_W;
            end
            OP_BEQ: begin
                alu_ina_s = fa_s;
                alu_inb_s = fb_s;
            end
            OP_JALR: begin
                alu_ina_s = pc_q;
                alu_inb_s = ONE_W;
            end
            default: begin
                alu_ina_s = fb_s;
                alu_inb_s = fc_s;
            end
        endcase
    end

    assign o_load_use    = load_use_s;
    assign o_valid       = valid_q;
    assign o_alu_op      = (opcode_q == OP_NAND);
    assign o_alu_ina     = alu_ina_s;
    assign o_alu_inb     = alu_inb_s;
    assign o_store_data  = fa_s;
    assign o_jump_target = fb_s;
    assign o_pc          = pc_q;
    assign o_opcode      = opcode_q;
    assign o_wr_en       = wr_en_q;
    assign o_wr_idx      = ra_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; covers both RISC16_FWD_EN builds.
module tb_id_ex_stage;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    logic        i_clk, i_rst;
    logic        i_dec_valid;
    logic [2:0]  i_dec_opcode, i_dec_ra, i_dec_rb, i_dec_rc;
    logic [15:0] i_dec_imm, i_dec_pc, i_rf_a, i_rf_b, i_rf_c;
    logic        i_mem_wr_en, i_wb_wr_en;
    logic [2:0]  i_mem_wr_idx, i_wb_wr_idx;
    logic [15:0] i_mem_wr_data, i_wb_wr_data;
    logic        i_stall, i_flush;
    logic        o_load_use, o_valid, o_alu_op, o_wr_en;
    logic [15:0] o_alu_ina, o_alu_inb, o_store_data, o_jump_target, o_pc;
    logic [2:0]  o_opcode, o_wr_idx;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.p_WORD_LEN(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_dec_valid(i_dec_valid), .i_dec_opcode(i_dec_opcode),
        .i_dec_ra(i_dec_ra), .i_dec_rb(i_dec_rb), .i_dec_rc(i_dec_rc),
        .i_dec_imm(i_dec_imm), .i_dec_pc(i_dec_pc),
        .i_rf_a(i_rf_a), .i_rf_b(i_rf_b), .i_rf_c(i_rf_c),
        .i_mem_wr_en(i_mem_wr_en), .i_mem_wr_idx(i_mem_wr_idx), .i_mem_wr_data(i_mem_wr_data),
        .i_wb_wr_en(i_wb_wr_en), .i_wb_wr_idx(i_wb_wr_idx), .i_wb_wr_data(i_wb_wr_data),
        .i_stall(i_stall), .i_flush(i_flush),
        .o_load_use(o_load_use), .o_valid(o_valid), .o_alu_op(o_alu_op),
        .o_alu_ina(o_alu_ina), .o_alu_inb(o_alu_inb),
        .o_store_data(o_store_data), .o_jump_target(o_jump_target),
        .o_pc(o_pc), .o_opcode(o_opcode), .o_wr_en(o_wr_en), .o_wr_idx(o_wr_idx)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        i_dec_valid = 1'b0; i_dec_opcode = 3'd0; i_dec_ra = 3'd0; i_dec_rb = 3'd0; i_dec_rc = 3'd0;
        i_dec_imm = 16'h0000; i_dec_pc = 16'h0000;
        i_rf_a = 16'h0000; i_rf_b = 16'h0000; i_rf_c = 16'h0000;
        i_mem_wr_en = 1'b0; i_mem_wr_idx = 3'd0; i_mem_wr_data = 16'h0000;
        i_wb_wr_en = 1'b0; i_wb_wr_idx = 3'd0; i_wb_wr_data = 16'h0000;
        i_stall = 1'b0; i_flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_dec(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [2:0] rc, input logic [15:0] imm, input logic [15:0] pc,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        i_dec_valid = 1'b1; i_dec_opcode = op; i_dec_ra = ra; i_dec_rb = rb; i_dec_rc = rc;
        i_dec_imm = imm; i_dec_pc = pc; i_rf_a = a; i_rf_b = b; i_rf_c = c;
    endtask

    // Capture one instruction, then leave decode empty and let outputs settle.
    task automatic capture(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [2:0] rc, input logic [15:0] imm, input logic [15:0] pc,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        set_dec(op, ra, rb, rc, imm, pc, a, b, c);
        tick();
        i_dec_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge i_clk);
        #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
        tests++; if (o_wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %b expected 0", o_wr_en); end
        tests++; if (o_load_use !== 1'b0) begin fails++; $display("FAIL rst_load_use: got %b expected 0", o_load_use); end
        tests++; if (o_alu_ina !== 16'h0000 || o_alu_inb !== 16'h0000) begin fails++; $display("FAIL rst_operands: got %h/%h expected 0000/0000", o_alu_ina, o_alu_inb); end
        tests++; if (o_opcode !== 3'd0 || o_pc !== 16'h0000) begin fails++; $display("FAIL rst_op_pc: got %0d/%h expected 0/0000", o_opcode, o_pc); end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        set_dec(OP_ADD, 3'd1, 3'd2, 3'd3, 16'h0000, 16'h0010, 16'h0000, 16'h0005, 16'h0007);
        #1;
        tests++; if (o_load_use !== 1'b0) begin fails++; $display("FAIL add_no_lu: got %b expected 0", o_load_use); end
        tick();
        i_dec_valid = 1'b0;
        #1;
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b expected 1", o_valid); end
        tests++; if (o_alu_ina !== 16'h0005 || o_alu_inb !== 16'h0007) begin fails++; $display("FAIL add_operands: got %h/%h expected 0005/0007", o_alu_ina, o_alu_inb); end
        tests++; if (o_alu_op !== 1'b0) begin fails++; $display("FAIL add_op: got %b expected 0", o_alu_op); end
        tests++; if (o_wr_en !== 1'b1 || o_wr_idx !== 3'd1) begin fails++; $display("FAIL add_wr: got %b/%0d expected 1/1", o_wr_en, o_wr_idx); end
        tests++; if (o_pc !== 16'h0010) begin fails++; $display("FAIL add_pc: got %h expected 0010", o_pc); end
        tick();
    endtask

    task automatic test_opcodes();
        capture(OP_ADDI, 3'd4, 3'd5, 3'd0, 16'hFFFF, 16'h0011, 16'h0000, 16'h0003, 16'h0000);
        tests++; if (o_alu_ina !== 16'h0003 || o_alu_inb !== 16'hFFFF) begin fails++; $display("FAIL addi_operands: got %h/%h expected 0003/ffff", o_alu_ina, o_alu_inb); end
        tests++; if (o_wr_en !== 1'b1 || o_wr_idx !== 3'd4) begin fails++; $display("FAIL addi_wr: got %b/%0d expected 1/4", o_wr_en, o_wr_idx); end
        tick();
        capture(OP_LUI, 3'd5, 3'd0, 3'd0, 16'hABC0, 16'h0012, 16'h0000, 16'h0000, 16'h0000);
        tests++; if (o_alu_ina !== 16'hABC0 || o_alu_inb !== 16'h0000) begin fails++; $display("FAIL lui_operands: got %h/%h expected abc0/0000", o_alu_ina, o_alu_inb); end
        tests++; if (o_wr_en !== 1'b1 || o_opcode !== OP_LUI) begin fails++; $display("FAIL lui_wr: got %b/%0d expected 1/3", o_wr_en, o_opcode); end
        tick();
        capture(OP_SW, 3'd3, 3'd2, 3'd0, 16'h0004, 16'h0013, 16'h0055, 16'h0010, 16'h0000);
        tests++; if (o_alu_ina !== 16'h0010 || o_alu_inb !== 16'h0004) begin fails++; $display("FAIL sw_operands: got %h/%h expected 0010/0004", o_alu_ina, o_alu_inb); end
        tests++; if (o_store_data !== 16'h0055) begin fails++; $display("FAIL sw_store_data: got %h expected 0055", o_store_data); end
        tests++; if (o_wr_en !== 1'b0) begin fails++; $display("FAIL sw_wr_en: got %b expected 0", o_wr_en); end
        tick();
        capture(OP_BEQ, 3'd1, 3'd2, 3'd0, 16'h0002, 16'h0014, 16'h0021, 16'h0022, 16'h0000);
        tests++; if (o_alu_ina !== 16'h0021 || o_alu_inb !== 16'h0022) begin fails++; $display("FAIL beq_operands: got %h/%h expected 0021/0022", o_alu_ina, o_alu_inb); end
        tests++; if (o_wr_en !== 1'b0) begin fails++; $display("FAIL beq_wr_en: got %b expected 0", o_wr_en); end
        tick();
        capture(OP_NAND, 3'd0, 3'd1, 3'd2, 16'h0000, 16'h0015, 16'h0000, 16'hF0F0, 16'h0FF0);
        tests++; if (o_alu_op !== 1'b1) begin fails++; $display("FAIL nand_op: got %b expected 1", o_alu_op); end
        tests++; if (o_alu_ina !== 16'hF0F0 || o_alu_inb !== 16'h0FF0) begin fails++; $display("FAIL nand_operands: got %h/%h expected f0f0/0ff0", o_alu_ina, o_alu_inb); end
        tests++; if (o_wr_en !== 1'b0) begin fails++; $display("FAIL nand_r0_wr_en: got %b expected 0", o_wr_en); end
        tick();
    endtask

    task automatic test_back_to_back();
        set_dec(OP_ADDI, 3'd1, 3'd2, 3'd0, 16'h0003, 16'h0050, 16'h0000, 16'h0010, 16'h0000);
        tick();
        set_dec(OP_LUI, 3'd6, 3'd0, 3'd0, 16'h1200, 16'h0051, 16'h0000, 16'h0000, 16'h0000);
        #1;
        tests++; if (o_alu_ina !== 16'h0010 || o_alu_inb !== 16'h0003 || o_wr_idx !== 3'd1) begin fails++; $display("FAIL b2b_first: got %h/%h/%0d expected 0010/0003/1", o_alu_ina, o_alu_inb, o_wr_idx); end
        tests++; if (o_load_use !== 1'b0) begin fails++; $display("FAIL b2b_no_lu: got %b expected 0", o_load_use); end
        tick();
        i_dec_valid = 1'b0;
        #1;
        tests++; if (o_valid !== 1'b1 || o_alu_ina !== 16'h1200 || o_wr_idx !== 3'd6) begin fails++; $display("FAIL b2b_second: got %b/%h/%0d expected 1/1200/6", o_valid, o_alu_ina, o_wr_idx); end
        tick();
    endtask

    task automatic test_stall();
        capture(OP_ADD, 3'd1, 3'd2, 3'd3, 16'h0000, 16'h0020, 16'h0000, 16'h0005, 16'h0007);
        i_stall = 1'b1;
        set_dec(OP_ADD, 3'd6, 3'd4, 3'd5, 16'h0000, 16'h0021, 16'h0009, 16'h0009, 16'h0009);
        tick();
        tests++; if (o_alu_ina !== 16'h0005 || o_alu_inb !== 16'h0007) begin fails++; $display("FAIL stall_operands: got %h/%h expected 0005/0007", o_alu_ina, o_alu_inb); end
        tests++; if (o_pc !== 16'h0020 || o_wr_idx !== 3'd1 || o_valid !== 1'b1) begin fails++; $display("FAIL stall_hold: got %h/%0d/%b expected 0020/1/1", o_pc, o_wr_idx, o_valid); end
        i_stall = 1'b0;
        i_dec_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush_stall();
        capture(OP_LW, 3'd3, 3'd2, 3'd0, 16'h0000, 16'h0030, 16'h0000, 16'h0100, 16'h0000);
        set_dec(OP_NAND, 3'd5, 3'd3, 3'd1, 16'h0000, 16'h0031, 16'h0000, 16'h0AAA, 16'h000F);
        #1;
        tests++; if (o_load_use !== 1'b1) begin fails++; $display("FAIL fs_lu_raw: got %b expected 1", o_load_use); end
        i_flush = 1'b1;
        i_stall = 1'b1;
        #1;
        tests++; if (o_load_use !== 1'b0) begin fails++; $display("FAIL fs_lu_forced: got %b expected 0", o_load_use); end
        tick();
        tests++; if (o_valid !== 1'b0 || o_wr_en !== 1'b0) begin fails++; $display("FAIL fs_bubble: got %b/%b expected 0/0", o_valid, o_wr_en); end
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_dec_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        capture(OP_LW, 3'd3, 3'd2, 3'd0, 16'h0000, 16'h0040, 16'h0000, 16'h0100, 16'h0000);
        set_dec(OP_NAND, 3'd5, 3'd3, 3'd1, 16'h0000, 16'h0041, 16'h0000, 16'h0AAA, 16'h000F);
        #1;
        tests++; if (o_load_use !== 1'b1) begin fails++; $display("FAIL lu_detect: got %b expected 1", o_load_use); end
        tick();
        i_mem_wr_en = 1'b1; i_mem_wr_idx = 3'd3; i_mem_wr_data = 16'hBEEF;
        #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble: got %b expected 0", o_valid); end
`ifdef RISC16_FWD_EN
        tests++; if (o_load_use !== 1'b0) begin fails++; $display("FAIL lu_release: got %b expected 0", o_load_use); end
        tick();
        i_mem_wr_en = 1'b0;
        i_wb_wr_en = 1'b1; i_wb_wr_idx = 3'd3; i_wb_wr_data = 16'hBEEF;
        i_dec_valid = 1'b0;
        #1;
`else
        tests++; if (o_load_use !== 1'b1) begin fails++; $display("FAIL lu_mem_hold: got %b expected 1", o_load_use); end
        tick();
        i_mem_wr_en = 1'b0;
        i_wb_wr_en = 1'b1; i_wb_wr_idx = 3'd3; i_wb_wr_data = 16'hBEEF;
        #1;
        tests++; if (o_load_use !== 1'b1) begin fails++; $display("FAIL lu_wb_hold: got %b expected 1", o_load_use); end
        tick();
        i_wb_wr_en = 1'b0;
        i_rf_b = 16'hBEEF;
        #1;
        tests++; if (o_load_use !== 1'b0) begin fails++; $display("FAIL lu_release: got %b expected 0", o_load_use); end
        tick();
        i_dec_valid = 1'b0;
        #1;
`endif
        tests++; if (o_valid !== 1'b1 || o_alu_op !== 1'b1 || o_wr_idx !== 3'd5) begin fails++; $display("FAIL lu_nand_ctl: got %b/%b/%0d expected 1/1/5", o_valid, o_alu_op, o_wr_idx); end
        tests++; if (o_alu_ina !== 16'hBEEF || o_alu_inb !== 16'h000F) begin fails++; $display("FAIL lu_nand_operands: got %h/%h expected beef/000f", o_alu_ina, o_alu_inb); end
        i_wb_wr_en = 1'b0;
        tick();
    endtask

    task automatic test_jalr();
        capture(OP_JALR, 3'd7, 3'd2, 3'd0, 16'h0000, 16'h00FF, 16'h0000, 16'h0011, 16'h0000);
        i_mem_wr_en = 1'b1; i_mem_wr_idx = 3'd2; i_mem_wr_data = 16'h0040;
        #1;
        tests++; if (o_alu_ina !== 16'h00FF || o_alu_inb !== 16'h0001) begin fails++; $display("FAIL jalr_operands: got %h/%h expected 00ff/0001", o_alu_ina, o_alu_inb); end
        tests++; if (o_wr_en !== 1'b1 || o_wr_idx !== 3'd7) begin fails++; $display("FAIL jalr_wr: got %b/%0d expected 1/7", o_wr_en, o_wr_idx); end
`ifdef RISC16_FWD_EN
        tests++; if (o_jump_target !== 16'h0040) begin fails++; $display("FAIL jalr_target: got %h expected 0040", o_jump_target); end
`else
        tests++; if (o_jump_target !== 16'h0011) begin fails++; $display("FAIL jalr_target: got %h expected 0011", o_jump_target); end
`endif
        i_mem_wr_en = 1'b0;
        tick();
    endtask

`ifdef RISC16_FWD_EN
    task automatic test_fwd_priority();
        capture(OP_ADD, 3'd4, 3'd2, 3'd0, 16'h0000, 16'h0060, 16'h0000, 16'h1111, 16'h0000);
        i_mem_wr_en = 1'b1; i_mem_wr_idx = 3'd2; i_mem_wr_data = 16'h1234;
        i_wb_wr_en = 1'b1; i_wb_wr_idx = 3'd2; i_wb_wr_data = 16'h9999;
        #1;
        tests++; if (o_alu_ina !== 16'h1234 || o_alu_inb !== 16'h0000) begin fails++; $display("FAIL fwd_mem_wins: got %h/%h expected 1234/0000", o_alu_ina, o_alu_inb); end
        i_mem_wr_en = 1'b0;
        #1;
        tests++; if (o_alu_ina !== 16'h9999) begin fails++; $display("FAIL fwd_wb: got %h expected 9999", o_alu_ina); end
        i_wb_wr_en = 1'b0;
        #1;
        tests++; if (o_alu_ina !== 16'h1111) begin fails++; $display("FAIL fwd_latched: got %h expected 1111", o_alu_ina); end
        i_mem_wr_en = 1'b1; i_mem_wr_idx = 3'd0; i_mem_wr_data = 16'hDEAD;
        #1;
        tests++; if (o_alu_inb !== 16'h0000) begin fails++; $display("FAIL fwd_r0: got %h expected 0000", o_alu_inb); end
        i_mem_wr_en = 1'b0;
        tick();
    endtask

    task automatic test_capture_bypass();
        set_dec(OP_ADD, 3'd1, 3'd2, 3'd3, 16'h0000, 16'h0070, 16'h0000, 16'h0001, 16'h0002);
        i_wb_wr_en = 1'b1; i_wb_wr_idx = 3'd2; i_wb_wr_data = 16'h2222;
        tick();
        i_wb_wr_en = 1'b0;
        i_dec_valid = 1'b0;
        #1;
        tests++; if (o_alu_ina !== 16'h2222 || o_alu_inb !== 16'h0002) begin fails++; $display("FAIL cap_bypass: got %h/%h expected 2222/0002", o_alu_ina, o_alu_inb); end
        tick();
    endtask
`else
    task automatic test_nofwd_wb_hazard();
        set_dec(OP_ADDI, 3'd1, 3'd2, 3'd0, 16'h0001, 16'h0080, 16'h0000, 16'h0005, 16'h0000);
        i_wb_wr_en = 1'b1; i_wb_wr_idx = 3'd2; i_wb_wr_data = 16'h0077;
        #1;
        tests++; if (o_load_use !== 1'b1) begin fails++; $display("FAIL nofwd_lu: got %b expected 1", o_load_use); end
        tick();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL nofwd_bubble: got %b expected 0", o_valid); end
        i_wb_wr_en = 1'b0;
        i_rf_b = 16'h0077;
        #1;
        tests++; if (o_load_use !== 1'b0) begin fails++; $display("FAIL nofwd_release: got %b expected 0", o_load_use); end
        tick();
        i_dec_valid = 1'b0;
        #1;
        tests++; if (o_valid !== 1'b1 || o_alu_ina !== 16'h0077 || o_alu_inb !== 16'h0001) begin fails++; $display("FAIL nofwd_capture: got %b/%h/%h expected 1/0077/0001", o_valid, o_alu_ina, o_alu_inb); end
        tick();
    endtask
`endif

    task automatic test_reset_mid_stall();
        capture(OP_ADD, 3'd1, 3'd2, 3'd3, 16'h0000, 16'h0090, 16'h0000, 16'h0005, 16'h0007);
        i_stall = 1'b1;
        i_dec_valid = 1'b1;
        #2;
        i_rst = 1'b1;
        #1;
        tests++; if (o_valid !== 1'b0 || o_wr_en !== 1'b0) begin fails++; $display("FAIL rst_mid_ctl: got %b/%b expected 0/0", o_valid, o_wr_en); end
        tests++; if (o_alu_ina !== 16'h0000 || o_pc !== 16'h0000) begin fails++; $display("FAIL rst_mid_data: got %h/%h expected 0000/0000", o_alu_ina, o_pc); end
        tick();
        i_rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_opcodes();
        test_back_to_back();
        test_stall();
        test_flush_stall();
        test_load_use();
        test_jalr();
`ifdef RISC16_FWD_EN
        test_fwd_priority();
        test_capture_bypass();
`else
        test_nofwd_wb_hazard();
`endif
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register and operand-select stage of the pipelined RiSC-16 core. Latches one decoded instruction per cycle and resolves RAW hazards by bypassing MEM/WB results or requesting a load-use stall. Drives the execute ALU's operation select and two operands directly, plus store data, jump target and writeback control for the downstream EX/MEM register.

## Interface
- p_WORD_LEN, 16, datapath and PC width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_dec_valid  in  1  decode slot holds a real instruction
- i_dec_opcode  in  3  RiSC-16 opcode (ADD 0, ADDI 1, NAND 2, LUI 3, SW 4, LW 5, BEQ 6, JALR 7)
- i_dec_ra / i_dec_rb / i_dec_rc  in  3 each  register fields
- i_dec_imm  in  p_WORD_LEN  immediate, pre-formatted by decode (sext7, or imm10<<6 for LUI)
- i_dec_pc  in  p_WORD_LEN  instruction PC
- i_rf_a / i_rf_b / i_rf_c  in  p_WORD_LEN each  register-file reads of ra/rb/rc
- i_mem_wr_en, i_mem_wr_idx(3), i_mem_wr_data(p_WORD_LEN)  in  pending write one stage ahead
- i_wb_wr_en, i_wb_wr_idx(3), i_wb_wr_data(p_WORD_LEN)  in  write committing this cycle
- i_stall  in  1  downstream hold
- i_flush  in  1  squash (taken branch / jump)
- o_load_use  out  1  combinational; decode must hold its instruction this cycle
- o_valid  out  1  EX slot valid
- o_alu_op  out  1  0 add, 1 nand
- o_alu_ina / o_alu_inb  out  p_WORD_LEN  ALU operands
- o_store_data  out  p_WORD_LEN  forwarded rA for SW
- o_jump_target  out  p_WORD_LEN  forwarded rB for JALR
- o_pc  out  p_WORD_LEN  latched PC
- o_opcode  out  3  latched opcode
- o_wr_en, o_wr_idx(3)  out  writeback control

## Operation
- Register update priority per edge: i_flush -> bubble (valid 0, wr_en 0); else i_stall -> hold all; else o_load_use -> bubble; else capture decode.
- Capture-time bypass: a source field equal to i_wb_wr_idx with i_wb_wr_en and index nonzero latches i_wb_wr_data instead of i_rf_*.
- Sources read: ADD/NAND rB,rC; ADDI/LW rB; SW/BEQ rA,rB; JALR rB; LUI none.
- EX-side forward per latched source: MEM match wins over WB match, WB over latched value; index 0 never forwarded, always reads 0.
- Operand map: ADD/NAND ina=rB, inb=rC; ADDI/LW/SW ina=rB, inb=imm; LUI ina=imm, inb=0; BEQ ina=rA, inb=rB; JALR ina=pc, inb=1. o_alu_op=1 only for NAND.
- o_wr_en = valid and opcode in {ADD,ADDI,NAND,LUI,LW,JALR} and ra≠0; o_wr_idx = ra.
- o_load_use = i_dec_valid and EX holds valid LW with o_wr_en and its ra matches a source the decode opcode reads; forced 0 when i_flush.
- Add wraps modulo 2^p_WORD_LEN.

## Timing
- Reset: all latched state 0; o_valid, o_wr_en, o_load_use 0; operands 0 (latched NOP-bubble, opcode 0).
- Latency: decode at edge N -> ALU operands valid after edge N+1; forwarding muxes are combinational within that cycle.
- Stall holds fields but forward muxes keep tracking live MEM/WB inputs.
- Reset mid-stall or mid-flush: asynchronous clear wins immediately.

## Configuration
- RISC16_FWD_EN defined: bypass paths as above.
- Undefined: no EX-side or capture bypass; o_load_use generalises to any source match against a valid writing instruction in EX, MEM or WB; operands come only from latched register-file values.

## Test plan
- ADD r1,r2,r3 with rf r2=5, r3=7, no hazards -> next cycle ina=5, inb=7, op 0, wr_idx 1, wr_en 1.
- MEM writes r2=0x1234, WB writes r2=0x9999, EX instr ADD r4,r2,r0 -> ina=0x1234, inb=0.
- EX holds LW r3; decode NAND r5,r3,r1 -> o_load_use=1, next cycle o_valid=0; following cycle NAND captured with forwarded load data.
- i_flush and i_stall together with valid decode -> o_valid=0 after edge, o_load_use=0.
- JALR r7,r2 at pc 0x00FF, MEM r2=0x0040 -> ina=0x00FF, inb=1, o_jump_target=0x0040, wr_idx 7.
- Without RISC16_FWD_EN: WB writing r2, decode ADDI r1,r2,1 -> o_load_use=1 one cycle, then captured with updated rf.
